axi2per_req_channel: RTL and testbench
======================================

AXI2PER_REQ_CHANNEL -- requirements
Module: axi2per_req_channel

Interface
REQ-001 SHALL have parameter PER_ADDR_WIDTH, default 32, peripheral address width.
REQ-002 SHALL have parameter PER_ID_WIDTH, default 8, one-hot peripheral ID width; it SHALL be at least 2**AXI_ID_WIDTH.
REQ-003 SHALL have parameters AXI_ADDR_WIDTH 32, AXI_DATA_WIDTH 64, AXI_USER_WIDTH 6 and AXI_ID_WIDTH 3 (defaults); AXI_STRB_WIDTH is fixed at AXI_DATA_WIDTH/8.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk_i  in  1  clock; rst_ni  in  1  async active-low reset.
REQ-005 AW: axi_slave_aw_valid_i in 1; aw_addr_i in AXI_ADDR_WIDTH; aw_len_i in 8; aw_size_i in 3; aw_id_i in AXI_ID_WIDTH; aw_ready_o out 1.
REQ-006 AR: axi_slave_ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_id_i (widths as AW); ar_ready_o out 1.
REQ-007 W: axi_slave_w_valid_i in 1; w_data_i in AXI_DATA_WIDTH; w_strb_i in AXI_STRB_WIDTH; w_last_i in 1; w_ready_o out 1.
REQ-008 Peripheral master: per_master_req_o out 1; add_o out PER_ADDR_WIDTH; we_o out 1 (0=write, 1=read); wdata_o out 32; be_o out 4; id_o out PER_ID_WIDTH; gnt_i in 1.
REQ-009 Control to the response channel: trans_req_o out 1; trans_we_o out 1; trans_id_o out AXI_ID_WIDTH; trans_last_o out 1; busy_o out 1.

Function
REQ-010 FSM states SHALL be IDLE, READ and WRITE; busy_o SHALL be 1 in any state other than IDLE.
REQ-011 IDLE: only one address channel SHALL be accepted per cycle; ar_ready_o or aw_ready_o SHALL be driven combinationally as 1 for the selected channel only.
REQ-012 On acceptance, the block SHALL register addr, len, min(size,2) and id, clear the beat counter, and move to READ or WRITE on the next cycle.
REQ-013 In IDLE, per_master_req_o and w_ready_o SHALL be 0.
REQ-014 READ: per_master_req_o=1, we_o=1, be_o=4'b1111.
REQ-015 READ: on gnt_i the block SHALL count the beat and advance the address.
REQ-016 WRITE: per_master_req_o SHALL equal w_valid_i, we_o=0, and w_ready_o SHALL equal gnt_i.
REQ-017 WRITE beat handshake SHALL be w_valid_i & gnt_i.
REQ-018 The per-beat address SHALL increment by (1<<size) after each beat (INCR); add_o SHALL be the registered address truncated to PER_ADDR_WIDTH.
REQ-019 Lane select SHALL be add[2]: 0 gives wdata_o=w_data_i[31:0], be_o=w_strb_i[3:0]; 1 gives wdata_o=w_data_i[63:32], be_o=w_strb_i[7:4].
REQ-020 id_o SHALL be one-hot, with bit[id]=1 and all other bits 0.
REQ-021 Each peripheral beat handshake SHALL pulse trans_req_o for exactly one cycle in the same cycle, with trans_we_o=~we_o, trans_id_o=registered id and trans_last_o=(count==len).
REQ-022 On the last beat (count==len) the FSM SHALL return to IDLE on the next cycle; a new address SHALL NOT be accepted in that same cycle.
REQ-023 The beat count SHALL govern burst end: w_last_i is ignored; len=0 gives exactly one beat and len=255 gives 256 beats.
REQ-024 The address SHALL wrap modulo 2**AXI_ADDR_WIDTH with no error.
REQ-025 gnt_i low in READ/WRITE SHALL hold all per_master outputs stable.

Reset
REQ-026 While rst_ni=0: state IDLE, counters, registered addr/len/size/id and priority flag 0; every output 0, except we_o=1.
REQ-027 Reset asserted mid-burst SHALL abort the burst immediately with no further trans_req_o pulses.

Configuration
REQ-028 Macro AXI2PER_RR_ARB_EN: defined gives round-robin when both AW and AR are valid in IDLE (a one-bit flag toggled on each acceptance, read-first after reset); undefined gives fixed read priority with the flag absent.

Verification
REQ-029 Single read: AR addr 0x104, len 0, id 2 -> ar_ready_o 1 cycle; then req=1, we=1, add=0x104, id_o=0x04; gnt_i -> trans_req 1, trans_last 1.
REQ-030 Write burst: AW addr 0x100, len 1, size 2; W beats 0x1111_2222_3333_4444 and 0x5555_6666_7777_8888 -> wdata 0x33334444 @0x100, then 0x55556666 @0x104; trans_last on beat 2 only.
REQ-031 Backpressure: gnt_i held 0 for 5 cycles in WRITE -> outputs stable, w_ready_o=0, no trans_req_o.
REQ-032 Simultaneous AW+AR valid twice: with macro, read then write; without macro, both grants go to read while AR stays valid.
REQ-033 Reset mid-burst: rst_ni=0 during beat 3 of a len 7 read -> all outputs 0 except we_o=1, IDLE; the next AR is accepted normally.
REQ-034 Wrap: AR addr 0xFFFF_FFFC, len 1 -> beat addresses 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/axi2per_req_channel.sv
// -----------------------------------------------------------------------------
// axi2per_req_channel
//
// Request half of an AXI-to-peripheral bridge. It accepts one AXI address
// (read or write) at a time, then issues one 32-bit peripheral access per
// burst beat. For writes, the W data stream is forwarded one beat at a time.
// Every peripheral handshake produces a one-cycle notice towards the response
// channel.
//
// Configuration macro:
//   AXI2PER_RR_ARB_EN  defined   -> round-robin between AW and AR when both
//                                   are valid in IDLE (read wins first after
//                                   reset)
//                      undefined -> fixed read priority
//
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   axi_slave_aw_*_i / aw_ready_o     AXI write address channel
//   axi_slave_ar_*_i / ar_ready_o     AXI read address channel
//   axi_slave_w_*_i  / w_ready_o      AXI write data channel (w_last ignored)
//   per_master_*                      peripheral request port (we=1 is read)
//   trans_*_o, busy_o                 per-beat notice to the response channel
// -----------------------------------------------------------------------------
module axi2per_req_channel #(
    parameter int PER_ADDR_WIDTH = 32,
    parameter int PER_ID_WIDTH   = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_ID_WIDTH   = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,

    input  logic                        axi_slave_aw_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_aw_addr_i,
    input  logic [7:0]                  axi_slave_aw_len_i,
    input  logic [2:0]                  axi_slave_aw_size_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_slave_aw_id_i,
    output logic                        axi_slave_aw_ready_o,

    input  logic                        axi_slave_ar_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_ar_addr_i,
    input  logic [7:0]                  axi_slave_ar_len_i,
    input  logic [2:0]                  axi_slave_ar_size_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_slave_ar_id_i,
    output logic                        axi_slave_ar_ready_o,

    input  logic                        axi_slave_w_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_slave_w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_slave_w_strb_i,
    input  logic                        axi_slave_w_last_i,
    output logic                        axi_slave_w_ready_o,

    output logic                        per_master_req_o,
    output logic [PER_ADDR_WIDTH-1:0]   per_master_add_o,
    output logic                        per_master_we_o,
    output logic [31:0]                 per_master_wdata_o,
    output logic [3:0]                  per_master_be_o,
    output logic [PER_ID_WIDTH-1:0]     per_master_id_o,
    input  logic                        per_master_gnt_i,

    output logic                        trans_req_o,
    output logic                        trans_we_o,
    output logic [AXI_ID_WIDTH-1:0]     trans_id_o,
    output logic                        trans_last_o,
    output logic                        busy_o
);

    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    // Elaboration-time sanity checks on the parameter set.
    generate
        if (PER_ID_WIDTH < (2 ** AXI_ID_WIDTH)) begin : g_bad_id_width
            $error("PER_ID_WIDTH must be at least 2**AXI_ID_WIDTH");
        end
        if (AXI_DATA_WIDTH < 64 || AXI_STRB_WIDTH < 8) begin : g_bad_data_width
            $error("AXI_DATA_WIDTH must be at least 64");
        end
        if (AXI_USER_WIDTH < 1) begin : g_bad_user_width
            $error("AXI_USER_WIDTH must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [7:0]                len_q,   len_d;
    logic [7:0]                count_q, count_d;
    logic [1:0]                size_q,  size_d;
    logic [AXI_ID_WIDTH-1:0]   id_q,    id_d;

    logic sel_read;
    logic sel_write;
    logic accept_rd;
    logic accept_wr;
    logic beat_hs;
    logic last_beat;
    logic lane_hi;

    // The bridge only carries 32-bit peripheral words, so wider beats are
    // clamped to 4 bytes.
    function automatic logic [1:0] clamp_size(input logic [2:0] s);
        return (s > 3'd2) ? 2'd2 : s[1:0];
    endfunction

    // ------------------------------------------------------------------
    // Address channel arbitration (only meaningful in IDLE)
    // ------------------------------------------------------------------
`ifdef AXI2PER_RR_ARB_EN
    logic rr_q;  // 0: read wins a tie, 1: write wins a tie

    assign sel_read = axi_slave_ar_valid_i & (~axi_slave_aw_valid_i | ~rr_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= 1'b0;
        end else if (accept_rd | accept_wr) begin
            rr_q <= ~rr_q;
        end
    end
`else
    assign sel_read = axi_slave_ar_valid_i;
`endif
    assign sel_write = axi_slave_aw_valid_i & ~sel_read;

    assign accept_rd = (state_q == IDLE) & sel_read;
    assign accept_wr = (state_q == IDLE) & sel_write;

    assign axi_slave_ar_ready_o = accept_rd;
    assign axi_slave_aw_ready_o = accept_wr;

    // ------------------------------------------------------------------
    // Peripheral side
    // ------------------------------------------------------------------
    assign busy_o    = (state_q != IDLE);
    assign lane_hi   = addr_q[2];
    assign last_beat = (count_q == len_q);

    assign per_master_req_o    = (state_q == READ) | ((state_q == WRITE) & axi_slave_w_valid_i);
    assign per_master_we_o     = (state_q != WRITE);
    assign axi_slave_w_ready_o = (state_q == WRITE) & per_master_gnt_i;

    // req is already qualified by w_valid in WRITE, so this covers both
    // the read handshake (gnt) and the write handshake (w_valid & gnt).
    assign beat_hs = per_master_req_o & per_master_gnt_i;

    always_comb begin
        per_master_wdata_o = '0;
        per_master_be_o    = 4'b0000;
        if (state_q == READ) begin
            per_master_be_o = 4'b1111;
        end else if (state_q == WRITE) begin
            if (lane_hi) begin
                per_master_wdata_o = axi_slave_w_data_i[63:32];
                per_master_be_o    = axi_slave_w_strb_i[7:4];
            end else begin
                per_master_wdata_o = axi_slave_w_data_i[31:0];
                per_master_be_o    = axi_slave_w_strb_i[3:0];
            end
        end
    end

    generate
        if (PER_ADDR_WIDTH <= AXI_ADDR_WIDTH) begin : g_add_trunc
            assign per_master_add_o = addr_q[PER_ADDR_WIDTH-1:0];
        end else begin : g_add_ext
            assign per_master_add_o = {{(PER_ADDR_WIDTH - AXI_ADDR_WIDTH){1'b0}}, addr_q};
        end
    endgenerate

    // One-hot ID is only presented while a burst is active so that the idle
    // and reset value of the port is all zeros.
    assign per_master_id_o = busy_o ? (PER_ID_WIDTH'(1) << id_q) : '0;

    assign trans_req_o  = beat_hs;
    assign trans_we_o   = beat_hs & (state_q == WRITE);
    assign trans_id_o   = beat_hs ? id_q : '0;
    assign trans_last_o = beat_hs & last_beat;

    // w_last is deliberately ignored: the beat counter alone ends a burst.
    logic unused_ok;
    assign unused_ok = axi_slave_w_last_i;

    // ------------------------------------------------------------------
    // FSM and burst bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        count_d = count_q;
        size_d  = size_q;
        id_d    = id_q;

        case (state_q)
            IDLE: begin
                if (accept_rd) begin
                    addr_d  = axi_slave_ar_addr_i;
                    len_d   = axi_slave_ar_len_i;
                    size_d  = clamp_size(axi_slave_ar_size_i);
                    id_d    = axi_slave_ar_id_i;
                    count_d = 8'd0;
                    state_d = READ;
                end else if (accept_wr) begin
                    addr_d  = axi_slave_aw_addr_i;
                    len_d   = axi_slave_aw_len_i;
                    size_d  = clamp_size(axi_slave_aw_size_i);
                    id_d    = axi_slave_aw_id_i;
                    count_d = 8'd0;
                    state_d = WRITE;
                end
            end
            READ, WRITE: begin
                if (beat_hs) begin
                    count_d = count_q + 8'd1;
                    // INCR burst; the sum wraps naturally at the address width.
                    addr_d  = addr_q + (AXI_ADDR_WIDTH'(1) << size_q);
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= 8'd0;
            count_q <= 8'd0;
            size_q  <= 2'd0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            count_q <= count_d;
            size_q  <= size_d;
            id_q    <= id_d;
        end
    end

endmodule

// File: tb/tb_axi2per_req_channel.sv
// -----------------------------------------------------------------------------
// tb_axi2per_req_channel
//
// Self-checking bench for axi2per_req_channel with default parameters.
// Inputs change just after the falling edge; outputs are sampled 1 ns later,
// well away from the rising edge. Honours AXI2PER_RR_ARB_EN when defined.
// -----------------------------------------------------------------------------
module tb_axi2per_req_channel;

`ifdef AXI2PER_RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aw_valid = 1'b0, ar_valid = 1'b0, w_valid = 1'b0, w_last = 1'b0, gnt = 1'b0;
    logic [31:0] aw_addr = '0, ar_addr = '0;
    logic [7:0]  aw_len = '0, ar_len = '0, w_strb = '0;
    logic [2:0]  aw_size = '0, ar_size = '0, aw_id = '0, ar_id = '0;
    logic [63:0] w_data = '0;

    logic        aw_ready, ar_ready, w_ready, req, we, trans_req, trans_we, trans_last, busy;
    logic [31:0] add, wdata;
    logic [3:0]  be;
    logic [7:0]  id_oh;
    logic [2:0]  trans_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi2per_req_channel dut (
        .clk_i(clk), .rst_ni(rst_n),
        .axi_slave_aw_valid_i(aw_valid), .axi_slave_aw_addr_i(aw_addr), .axi_slave_aw_len_i(aw_len),
        .axi_slave_aw_size_i(aw_size), .axi_slave_aw_id_i(aw_id), .axi_slave_aw_ready_o(aw_ready),
        .axi_slave_ar_valid_i(ar_valid), .axi_slave_ar_addr_i(ar_addr), .axi_slave_ar_len_i(ar_len),
        .axi_slave_ar_size_i(ar_size), .axi_slave_ar_id_i(ar_id), .axi_slave_ar_ready_o(ar_ready),
        .axi_slave_w_valid_i(w_valid), .axi_slave_w_data_i(w_data), .axi_slave_w_strb_i(w_strb),
        .axi_slave_w_last_i(w_last), .axi_slave_w_ready_o(w_ready),
        .per_master_req_o(req), .per_master_add_o(add), .per_master_we_o(we),
        .per_master_wdata_o(wdata), .per_master_be_o(be), .per_master_id_o(id_oh),
        .per_master_gnt_i(gnt),
        .trans_req_o(trans_req), .trans_we_o(trans_we), .trans_id_o(trans_id),
        .trans_last_o(trans_last), .busy_o(busy)
    );

    // Observation vectors: every output, the control flags, and the beat
    // fields (response-channel fields only matter while trans_req is high).
    wire [87:0] all_obs  = {busy, req, we, add, wdata, be, id_oh, w_ready,
                            trans_req, trans_we, trans_id, trans_last, ar_ready, aw_ready};
    wire [6:0]  ctl_obs  = {busy, req, we, w_ready, trans_req, ar_ready, aw_ready};
    wire [48:0] beat_obs = {add, be, id_oh, (trans_req ? {trans_we, trans_id, trans_last} : 5'b0)};

    localparam logic [87:0] RESET_VEC = {2'b00, 1'b1, 85'd0};

    task automatic set_ar(input logic v, input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [2:0] i);
        ar_valid = v; ar_addr = a; ar_len = l; ar_size = s; ar_id = i;
    endtask

    task automatic set_aw(input logic v, input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [2:0] i);
        aw_valid = v; aw_addr = a; aw_len = l; aw_size = s; aw_id = i;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (all_obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_outputs: got %h required %h", all_obs, RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctl_obs !== 7'b0010000) begin
            errors++;
            $display("FAIL reset_release_idle: got %b required %b", ctl_obs, 7'b0010000);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        @(negedge clk);
        set_ar(1'b1, 32'h104, 8'd0, 3'd2, 3'd2);
        #1;
        checks++;
        if (ctl_obs !== 7'b0010010) begin
            errors++;
            $display("FAIL read_accept: got %b required %b", ctl_obs, 7'b0010010);
        end
        @(negedge clk);
        ar_valid = 1'b0;
        #1;
        checks++;
        if ({ctl_obs, beat_obs} !== {7'b1110000, 32'h104, 4'hF, 8'h04, 5'b0}) begin
            errors++;
            $display("FAIL read_wait: got %b %h required %b %h", ctl_obs, beat_obs,
                     7'b1110000, {32'h104, 4'hF, 8'h04, 5'b0});
        end
        @(negedge clk);
        gnt = 1'b1;
        #1;
        checks++;
        if ({ctl_obs, beat_obs} !== {7'b1110100, 32'h104, 4'hF, 8'h04, 1'b0, 3'd2, 1'b1}) begin
            errors++;
            $display("FAIL read_beat: got %b %h", ctl_obs, beat_obs);
        end
        @(negedge clk);
        gnt = 1'b0;
        #1;
        checks++;
        if (ctl_obs !== 7'b0010000) begin
            errors++;
            $display("FAIL read_back_idle: got %b required %b", ctl_obs, 7'b0010000);
        end
        $display("test_single_read done");
    endtask

    task automatic test_write_burst();
        @(negedge clk);
        set_aw(1'b1, 32'h100, 8'd1, 3'd2, 3'd5);
        #1;
        checks++;
        if (ctl_obs !== 7'b0010001) begin
            errors++;
            $display("FAIL write_accept: got %b required %b", ctl_obs, 7'b0010001);
        end
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b1; gnt = 1'b1;
        w_data = 64'h1111_2222_3333_4444; w_strb = 8'hA5; w_last = 1'b0;
        #1;
        checks++;
        if ({ctl_obs, beat_obs, wdata} !== {7'b1101100, 32'h100, 4'h5, 8'h20, 1'b1, 3'd5, 1'b0, 32'h3333_4444}) begin
            errors++;
            $display("FAIL write_beat1: got %b %h %h", ctl_obs, beat_obs, wdata);
        end
        @(negedge clk);
        w_data = 64'h5555_6666_7777_8888; w_strb = 8'h3C; w_last = 1'b1;
        #1;
        checks++;
        if ({ctl_obs, beat_obs, wdata} !== {7'b1101100, 32'h104, 4'h3, 8'h20, 1'b1, 3'd5, 1'b1, 32'h5555_6666}) begin
            errors++;
            $display("FAIL write_beat2: got %b %h %h", ctl_obs, beat_obs, wdata);
        end
        @(negedge clk);
        w_valid = 1'b0; gnt = 1'b0; w_last = 1'b0;
        #1;
        checks++;
        if (ctl_obs !== 7'b0010000) begin
            errors++;
            $display("FAIL write_back_idle: got %b required %b", ctl_obs, 7'b0010000);
        end
        $display("test_write_burst done");
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        set_aw(1'b1, 32'h204, 8'd0, 3'd2, 3'd1);
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b1; gnt = 1'b0;
        w_data = 64'hDEAD_BEEF_0BAD_F00D; w_strb = 8'h9F;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({ctl_obs, beat_obs, wdata} !== {7'b1100000, 32'h204, 4'h9, 8'h02, 5'b0, 32'hDEAD_BEEF}) begin
                errors++;
                $display("FAIL backpressure_hold cycle %0d: got %b %h %h", c, ctl_obs, beat_obs, wdata);
            end
            @(negedge clk);
        end
        gnt = 1'b1;
        #1;
        checks++;
        if ({ctl_obs, beat_obs} !== {7'b1101100, 32'h204, 4'h9, 8'h02, 1'b1, 3'd1, 1'b1}) begin
            errors++;
            $display("FAIL backpressure_release: got %b %h", ctl_obs, beat_obs);
        end
        @(negedge clk);
        gnt = 1'b0; w_valid = 1'b0;
        $display("test_backpressure done");
    endtask

    task automatic test_arbitration();
        bit exp_rd;
        // Start from reset so the round-robin flag is in its read-first state.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            set_ar(1'b1, 32'h400, 8'd0, 3'd2, 3'd3);
            set_aw(1'b1, 32'h500, 8'd0, 3'd2, 3'd4);
            gnt = 1'b0; w_valid = 1'b0;
            exp_rd = RR ? (j % 2 == 0) : 1'b1;
            #1;
            checks++;
            if ({busy, ar_ready, aw_ready} !== {1'b0, exp_rd, !exp_rd}) begin
                errors++;
                $display("FAIL arb_grant %0d: got busy/ar/aw %b required %b", j,
                         {busy, ar_ready, aw_ready}, {1'b0, exp_rd, !exp_rd});
            end
            @(negedge clk);
            ar_valid = 1'b0; aw_valid = 1'b0; gnt = 1'b1; w_valid = 1'b1;
            #1;
            checks++;
            if ({busy, we, trans_req, trans_we, trans_last} !== {1'b1, exp_rd, 1'b1, !exp_rd, 1'b1}) begin
                errors++;
                $display("FAIL arb_beat %0d: got %b required %b", j,
                         {busy, we, trans_req, trans_we, trans_last}, {1'b1, exp_rd, 1'b1, !exp_rd, 1'b1});
            end
        end
        @(negedge clk);
        gnt = 1'b0; w_valid = 1'b0;
        $display("test_arbitration done");
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        set_ar(1'b1, 32'h300, 8'd7, 3'd2, 3'd3);
        @(negedge clk);
        ar_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            gnt = 1'b1;
            #1;
            checks++;
            if ({trans_req, add} !== {1'b1, 32'h300 + 32'(4 * b)}) begin
                errors++;
                $display("FAIL midrst_beat %0d: got req %b add %h", b, trans_req, add);
            end
            if (b < 2) @(negedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_obs !== RESET_VEC) begin
            errors++;
            $display("FAIL midrst_outputs: got %h required %h", all_obs, RESET_VEC);
        end
        @(posedge clk);
        #1;
        checks++;
        if (all_obs !== RESET_VEC) begin
            errors++;
            $display("FAIL midrst_held: got %h required %h", all_obs, RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1; gnt = 1'b0;
        set_ar(1'b1, 32'h40, 8'd0, 3'd2, 3'd0);
        #1;
        checks++;
        if (ctl_obs !== 7'b0010010) begin
            errors++;
            $display("FAIL midrst_next_accept: got %b required %b", ctl_obs, 7'b0010010);
        end
        @(negedge clk);
        ar_valid = 1'b0; gnt = 1'b1;
        #1;
        checks++;
        if ({ctl_obs, beat_obs} !== {7'b1110100, 32'h40, 4'hF, 8'h01, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL midrst_next_beat: got %b %h", ctl_obs, beat_obs);
        end
        @(negedge clk);
        gnt = 1'b0;
        $display("test_reset_mid_burst done");
    endtask

    task automatic test_wrap();
        @(negedge clk);
        set_ar(1'b1, 32'hFFFF_FFFC, 8'd1, 3'd2, 3'd7);
        @(negedge clk);
        ar_valid = 1'b0; gnt = 1'b1;
        #1;
        checks++;
        if (beat_obs !== {32'hFFFF_FFFC, 4'hF, 8'h80, 1'b0, 3'd7, 1'b0}) begin
            errors++;
            $display("FAIL wrap_beat1: got %h", beat_obs);
        end
        @(negedge clk);
        #1;
        checks++;
        if (beat_obs !== {32'h0000_0000, 4'hF, 8'h80, 1'b0, 3'd7, 1'b1}) begin
            errors++;
            $display("FAIL wrap_beat2: got %h", beat_obs);
        end
        @(negedge clk);
        gnt = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_idle: got busy %b required 0", busy);
        end
        $display("test_wrap done");
    endtask

    // Random bursts: the expected beat address is base + k * bytes, the beat
    // completes when gnt (and w_valid for writes) is high, and exactly len+1
    // beats are produced. Junk address valids during the burst must never be
    // accepted, including in the cycle of the last beat.
    task automatic test_random_bursts();
        for (int b = 0; b < 40; b++) begin
            bit          rd, g, wv, hs;
            int unsigned len, sz, bytes, k, cyc;
            logic [31:0] base, ea;
            logic [2:0]  bid;
            logic [63:0] wd;
            logic [7:0]  ws;
            logic [3:0]  ebe;

            rd    = 1'($urandom_range(0, 1));
            len   = (b == 7) ? 255 : $urandom_range(0, 7);
            sz    = $urandom_range(0, 7);
            bytes = (sz > 2) ? 4 : (1 << sz);
            base  = (b % 5 == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            bid   = 3'($urandom_range(0, 7));

            @(negedge clk);
            set_ar(rd, base, 8'(len), 3'(sz), bid);
            set_aw(!rd, base, 8'(len), 3'(sz), bid);
            gnt = 1'b0; w_valid = 1'b0;
            #1;
            checks++;
            if ({busy, ar_ready, aw_ready} !== {1'b0, rd, !rd}) begin
                errors++;
                $display("FAIL rnd_accept burst %0d: got %b required %b", b,
                         {busy, ar_ready, aw_ready}, {1'b0, rd, !rd});
            end

            k = 0;
            cyc = 0;
            while (k <= len && cyc < 2000) begin
                @(negedge clk);
                cyc++;
                g  = ($urandom_range(0, 3) != 0);
                wv = ($urandom_range(0, 3) != 0);
                wd = {$urandom, $urandom};
                ws = 8'($urandom);
                gnt = g; w_valid = wv; w_data = wd; w_strb = ws;
                w_last = 1'($urandom_range(0, 1));
                ar_valid = 1'($urandom_range(0, 1)); ar_addr = $urandom;
                aw_valid = 1'($urandom_range(0, 1)); aw_addr = $urandom;
                #1;
                ea  = base + 32'(k * bytes);
                hs  = g && (rd || wv);
                ebe = rd ? 4'hF : (ea[2] ? ws[7:4] : ws[3:0]);
                checks++;
                if (ctl_obs !== {1'b1, (rd | wv), rd, (!rd & g), hs, 2'b00}) begin
                    errors++;
                    $display("FAIL rnd_ctl burst %0d beat %0d: got %b required %b", b, k,
                             ctl_obs, {1'b1, (rd | wv), rd, (!rd & g), hs, 2'b00});
                end
                checks++;
                if (beat_obs !== {ea, ebe, 8'(1 << bid), (hs ? {!rd, bid, (k == len)} : 4'b0), (hs ? 1'b0 : 1'b0)} &&
                    beat_obs !== {ea, ebe, 8'(1 << bid), (hs ? {!rd, bid, (k == len)} : 5'b0)}) begin
                    errors++;
                    $display("FAIL rnd_beat burst %0d beat %0d: got %h required %h", b, k,
                             beat_obs, {ea, ebe, 8'(1 << bid), (hs ? {!rd, bid, (k == len)} : 5'b0)});
                end
                if (!rd) begin
                    checks++;
                    if (wdata !== (ea[2] ? wd[63:32] : wd[31:0])) begin
                        errors++;
                        $display("FAIL rnd_wdata burst %0d beat %0d: got %h required %h", b, k,
                                 wdata, (ea[2] ? wd[63:32] : wd[31:0]));
                    end
                end
                if (hs) k++;
            end
            if (k <= len) begin
                checks++;
                errors++;
                $display("FAIL rnd_timeout burst %0d: beats %0d required %0d", b, k, len + 1);
            end
            @(negedge clk);
            ar_valid = 1'b0; aw_valid = 1'b0; gnt = 1'b0; w_valid = 1'b0;
            #1;
            checks++;
            if ({busy, req, trans_req} !== 3'b000) begin
                errors++;
                $display("FAIL rnd_end burst %0d: got busy/req/treq %b required 000", b,
                         {busy, req, trans_req});
            end
            $display("rnd burst %0d: %s len %0d size %0d base %h id %0d beats %0d cycles %0d",
                     b, rd ? "read" : "write", len, sz, base, bid, k, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_burst();
        test_backpressure();
        test_arbitration();
        test_reset_mid_burst();
        test_wrap();
        test_random_bursts();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached (checks %0d errors %0d)", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
